// File: rtl/mux41_d.sv
// Registered 4:1 lane selector with per-lane mask; out/out_valid follow the sampled lane one cycle late.
// out_comb is the same selection with no register stage; there is no backpressure, and en only gates the load.
module mux41_d #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [4*WIDTH-1:0] in,
    input  logic [1:0]         sel,
    input  logic [3:0]         lane_mask,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_comb
);

    logic [WIDTH-1:0] w_lane;
    logic             w_lane_en;
    logic [WIDTH-1:0] w_sel_data;
    logic [WIDTH-1:0] r_out;
    logic             r_valid;

    // Explicit case keeps unselected lanes (even X/Z) out of the result.
    always_comb begin
        w_lane = '0;
        case (sel)
            2'd0:    w_lane = in[0*WIDTH +: WIDTH];
            2'd1:    w_lane = in[1*WIDTH +: WIDTH];
            2'd2:    w_lane = in[2*WIDTH +: WIDTH];
            default: w_lane = in[3*WIDTH +: WIDTH];
        endcase
    end

    assign w_lane_en  = lane_mask[sel];
    assign w_sel_data = w_lane_en ? w_lane : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= en;
            if (en) begin
                r_out <= w_sel_data;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_valid;
    assign out_comb  = w_sel_data;

endmodule

// File: tb/tb_mux41_d.sv
// Directed bench for mux41_d: a 1-bit instance for the classic mux cases and an 8-bit instance for lane width.
module tb_mux41_d;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] sel;
    logic [3:0] lane_mask;
    logic [3:0] in1;
    logic [31:0] in8;
    logic       out1;
    logic       out_valid1;
    logic       out_comb1;
    logic [7:0] out8;
    logic       out_valid8;
    logic [7:0] out_comb8;

    int checks;
    int errors;

    mux41_d #(.WIDTH(1)) u_mux1 (
        .clk(clk), .rst(rst), .en(en), .in(in1), .sel(sel), .lane_mask(lane_mask),
        .out(out1), .out_valid(out_valid1), .out_comb(out_comb1)
    );

    mux41_d #(.WIDTH(8)) u_mux8 (
        .clk(clk), .rst(rst), .en(en), .in(in8), .sel(sel), .lane_mask(lane_mask),
        .out(out8), .out_valid(out_valid8), .out_comb(out_comb8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] onehot_in [4];
    logic [3:0] compl_in  [4];

    initial begin
        checks = 0;
        errors = 0;
        onehot_in[0] = 4'b0001; onehot_in[1] = 4'b0010;
        onehot_in[2] = 4'b0100; onehot_in[3] = 4'b1000;
        compl_in[0]  = 4'b1110; compl_in[1]  = 4'b1101;
        compl_in[2]  = 4'b1011; compl_in[3]  = 4'b0111;

        rst = 1'b1; en = 1'b1; sel = 2'd0; lane_mask = 4'b1111;
        in1 = 4'b1111; in8 = 32'h0;
        #2;
        chk("rst_out", 8'(out1), 8'd0);
        chk("rst_valid", 8'(out_valid1), 8'd0);
        chk("rst_comb", 8'(out_comb1), 8'd1);
        tick();
        chk("rst_edge_out", 8'(out1), 8'd0);
        chk("rst_edge_valid", 8'(out_valid1), 8'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_out", 8'(out1), 8'd1);
        chk("post_rst_valid", 8'(out_valid1), 8'd1);

        for (int i = 0; i < 4; i++) begin
            in1 = onehot_in[i]; sel = 2'(i);
            #1;
            chk("onehot_comb", 8'(out_comb1), 8'd1);
            tick();
            chk("onehot_out", 8'(out1), 8'd1);
            chk("onehot_valid", 8'(out_valid1), 8'd1);
        end

        for (int i = 0; i < 4; i++) begin
            in1 = compl_in[i]; sel = 2'(i);
            #1;
            chk("compl_comb", 8'(out_comb1), 8'd0);
            tick();
            chk("compl_out", 8'(out1), 8'd0);
        end

        in1 = 4'b1000; sel = 2'd0;
        tick();
        chk("top_sel0", 8'(out1), 8'd0);
        sel = 2'd3;
        tick();
        chk("top_sel3", 8'(out1), 8'd1);

        en = 1'b0; in1 = 4'b1110; sel = 2'd0;
        #1;
        chk("hold_comb", 8'(out_comb1), 8'd0);
        tick();
        chk("hold_out", 8'(out1), 8'd1);
        chk("hold_valid", 8'(out_valid1), 8'd0);
        in1 = 4'b0100; sel = 2'd2;
        #1;
        chk("hold_comb2", 8'(out_comb1), 8'd1);

        en = 1'b1; in1 = 4'b1111; sel = 2'd2; lane_mask = 4'b1011;
        #1;
        chk("mask_comb", 8'(out_comb1), 8'd0);
        tick();
        chk("mask_out", 8'(out1), 8'd0);
        lane_mask = 4'b1111;
        #1;
        chk("unmask_comb", 8'(out_comb1), 8'd1);
        tick();
        chk("unmask_out", 8'(out1), 8'd1);

        in8 = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        sel = 2'd0;
        #1;
        chk("w8_comb0", out_comb8, 8'hA1);
        tick();
        chk("w8_out0", out8, 8'hA1);
        sel = 2'd1;
        tick();
        chk("w8_out1", out8, 8'hB2);
        sel = 2'd2;
        tick();
        chk("w8_out2", out8, 8'hC3);
        chk("w8_valid", 8'(out_valid8), 8'd1);
        lane_mask = 4'b0111;
        sel = 2'd3;
        #1;
        chk("w8_mask_comb", out_comb8, 8'h00);
        lane_mask = 4'b1111;
        tick();
        chk("w8_out3", out8, 8'hD4);
        #2;
        rst = 1'b1;
        #1;
        chk("w8_midrst_out", out8, 8'h00);
        chk("w8_midrst_valid", 8'(out_valid8), 8'd0);
        chk("w8_midrst_comb", out_comb8, 8'hD4);
        tick();
        rst = 1'b0;
        en = 1'b0;
        tick();
        chk("w8_norel_load", out8, 8'h00);
        en = 1'b1;
        tick();
        chk("w8_reload", out8, 8'hD4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
